// File: rtl/ysyx_25030093_idu_pkg.sv
// Shared encodings for the ysyx_25030093 instruction decode stage.
package ysyx_25030093_idu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_CSRRW = 4'd10,
    ALU_CSRRS = 4'd11,
    ALU_CSRRC = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JAL  = 3'd1,
    BR_JALR = 3'd2,
    BR_COND = 3'd3,
    BR_TRAP = 3'd4
  } br_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_op_e     alu_op;
    src_a_e      src_a;
    src_b_e      src_b;
    br_op_e      br_op;
    logic [2:0]  mem_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        wen;
    logic        csr_en;
    logic        ecall;
    logic        mret;
    logic        ebreak;
    logic        illegal;
  } idu_bundle_t;

  // Integer ALU op for OP/OP-IMM; alt selects sub/sra (inst[30]).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030093_idu_dec.sv
// Combinational RV32I/E + Zicsr decoder producing the control bundle.
module ysyx_25030093_idu_dec
  import ysyx_25030093_idu_pkg::*;
#(
  parameter int RV32E    = 0,
  parameter int EN_ZICSR = 1
) (
  input  logic [31:0] inst,
  output idu_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  idu_bundle_t b;
  logic ill, use_rd, use_rs1, use_rs2, zimm;

  // Format decode, legality check, then illegal squash of side effects.
  always_comb begin
    b       = '0;
    b.imm   = imm_i;
    ill     = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    zimm    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        use_rd = 1'b1; b.imm = imm_u; b.src_a = SRC_A_ZERO; b.src_b = SRC_B_IMM; b.wen = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; b.imm = imm_u; b.src_a = SRC_A_PC; b.src_b = SRC_B_IMM; b.wen = 1'b1;
      end
      OPC_JAL: begin
        use_rd = 1'b1; b.imm = imm_j; b.src_a = SRC_A_PC; b.src_b = SRC_B_FOUR;
        b.br_op = BR_JAL; b.wen = 1'b1;
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; b.src_a = SRC_A_PC; b.src_b = SRC_B_FOUR;
        b.br_op = BR_JALR; b.wen = 1'b1; ill = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; b.imm = imm_b; b.br_op = BR_COND; b.mem_op = f3;
        b.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        ill = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; b.src_b = SRC_B_IMM; b.mem_rd = 1'b1;
        b.mem_op = f3; b.wen = 1'b1; ill = (f3 == 3'd3) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; b.imm = imm_s; b.src_b = SRC_B_IMM;
        b.mem_wr = 1'b1; b.mem_op = f3; ill = f3[2] || (f3 == 3'd3);
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; b.src_b = SRC_B_IMM; b.wen = 1'b1;
        b.alu_op = alu_from_f3(f3, (f3 == 3'd5) && inst[30]);
        if (f3 == 3'd1) ill = (f7 != 7'h00);
        if (f3 == 3'd5) ill = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; b.wen = 1'b1;
        b.alu_op = alu_from_f3(f3, inst[30]);
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OPC_FENCE: begin
        b.imm = '0; ill = (f3 != 3'd0);
      end
      OPC_SYSTEM: begin
        if (f3 == 3'd0) begin
          b.imm = '0;
          if (inst == INST_ECALL) begin
            b.ecall = 1'b1; b.br_op = BR_TRAP;
          end else if (inst == INST_MRET) begin
            b.mret = 1'b1; b.br_op = BR_TRAP;
          end else if (inst == INST_EBREAK) begin
            b.ebreak = 1'b1;
          end else begin
            ill = 1'b1;
          end
        end else begin
          // rs1 field is a 5-bit zimm for the immediate forms, so it is
          // carried but not subject to the RV32E register range check.
          use_rd = 1'b1; use_rs1 = !f3[2]; zimm = f3[2];
          b.src_b = SRC_B_IMM; b.csr_en = 1'b1; b.wen = 1'b1; b.mem_op = f3;
          case (f3[1:0])
            2'd1:    b.alu_op = ALU_CSRRW;
            2'd2:    b.alu_op = ALU_CSRRS;
            2'd3:    b.alu_op = ALU_CSRRC;
            default: ill = 1'b1;
          endcase
          if (EN_ZICSR == 0) ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase

    b.rd  = use_rd ? inst[11:7] : 5'd0;
    b.rs1 = (use_rs1 || zimm) ? inst[19:15] : 5'd0;
    b.rs2 = use_rs2 ? inst[24:20] : 5'd0;
    if ((RV32E != 0) && ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24])))
      ill = 1'b1;
    if (b.rd == 5'd0) b.wen = 1'b0;

    if (ill) begin
      b.rd     = inst[11:7];
      b.rs1    = inst[19:15];
      b.rs2    = inst[24:20];
      b.wen    = 1'b0;
      b.mem_rd = 1'b0;
      b.mem_wr = 1'b0;
      b.csr_en = 1'b0;
      b.ecall  = 1'b0;
      b.mret   = 1'b0;
      b.ebreak = 1'b0;
      b.br_op  = BR_NONE;
    end
    b.illegal = ill;
  end

  assign bundle = b;

endmodule

// File: rtl/ysyx_25030093_idu_pipe.sv
// IDU stage: decoder followed by a main output register and one skid entry.
module ysyx_25030093_idu_pipe
  import ysyx_25030093_idu_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int RV32E    = 0,
  parameter int EN_ZICSR = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic [3:0]      alu_op,
  output logic [1:0]      src_a,
  output logic [1:0]      src_b,
  output logic [2:0]      br_op,
  output logic [2:0]      mem_op,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            wen,
  output logic            csr_en,
  output logic            ecall,
  output logic            mret,
  output logic            ebreak,
  output logic            illegal
);

  // Stage p0: combinational decode of the incoming instruction.
  idu_bundle_t dec_p0;

  ysyx_25030093_idu_dec #(
    .RV32E    (RV32E),
    .EN_ZICSR (EN_ZICSR)
  ) u_dec (
    .inst   (in_inst),
    .bundle (dec_p0)
  );

  // Stage p1: main output entry plus skid entry behind it.
  idu_bundle_t     main_p1, skid_p1;
  logic [PC_W-1:0] pc_main_p1, pc_skid_p1;
  logic            vld_p1, vld_skid_p1;
  logic            accept, drain;

  assign accept = in_valid && in_ready;
  assign drain  = vld_p1 && out_ready;

  // Two-entry FIFO: new entries fill main when it is free or draining,
  // otherwise park in skid; skid refills main as soon as main drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      vld_skid_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
      pc_main_p1  <= '0;
      pc_skid_p1  <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (vld_skid_p1) begin
      if (drain) begin
        main_p1     <= skid_p1;
        pc_main_p1  <= pc_skid_p1;
        vld_skid_p1 <= 1'b0;
      end
    end else if (accept) begin
      if (!vld_p1 || drain) begin
        main_p1    <= dec_p0;
        pc_main_p1 <= in_pc;
        vld_p1     <= 1'b1;
      end else begin
        skid_p1     <= dec_p0;
        pc_skid_p1  <= in_pc;
        vld_skid_p1 <= 1'b1;
      end
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  assign in_ready  = !vld_skid_p1;
  assign out_valid = vld_p1;
  assign out_pc    = pc_main_p1;
  assign rd        = main_p1.rd;
  assign rs1       = main_p1.rs1;
  assign rs2       = main_p1.rs2;
  assign imm       = main_p1.imm;
  assign alu_op    = main_p1.alu_op;
  assign src_a     = main_p1.src_a;
  assign src_b     = main_p1.src_b;
  assign br_op     = main_p1.br_op;
  assign mem_op    = main_p1.mem_op;
  assign mem_rd    = main_p1.mem_rd;
  assign mem_wr    = main_p1.mem_wr;
  assign wen       = main_p1.wen;
  assign csr_en    = main_p1.csr_en;
  assign ecall     = main_p1.ecall;
  assign mret      = main_p1.mret;
  assign ebreak    = main_p1.ebreak;
  assign illegal   = main_p1.illegal;

endmodule
